// File: rtl/pc_trace_pkg.sv
// Shared types for the PC trace buffer.
// Define PC_TRACE_TIMESTAMP_EN to stamp every entry with a cycle count.
package pc_trace_pkg;

  localparam int ADDR_W_D = 8;
  localparam int CMD_W_D  = 24;
  localparam int TS_W     = 16;
  localparam int POST_W   = 8;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    TRIGGERED,
    DONE
  } trace_state_e;

  typedef struct packed {
    logic [ADDR_W_D-1:0] addr;
    logic [CMD_W_D-1:0]  cmd;
    logic                trig;
`ifdef PC_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]     ts;
`endif
  } trace_entry_t;

  function automatic logic is_capturing(
    input trace_state_e s
  );
    return (s == ARMED) || (s == TRIGGERED);
  endfunction

endpackage

// File: rtl/pc_trace_mem.sv
// Circular trace storage: one write port, one
// combinational read port addressed by the top.
module pc_trace_mem
  import pc_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_wr_en,
  input  logic [PTR_W-1:0]   i_wr_addr,
  input  trace_entry_t       i_wr_data,
  input  logic [PTR_W-1:0]   i_rd_addr,
  output trace_entry_t       o_rd_data
);

  trace_entry_t r_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/pc_trace_buffer.sv
// Pre/post-trigger PC trace capture with a valid/ready drain port.
// PC_TRACE_TIMESTAMP_EN adds a 16-bit per-entry timestamp on trc_ts.
module pc_trace_buffer
  import pc_trace_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int CMD_W  = CMD_W_D,
  parameter int DEPTH  = 16,
  parameter int DROP_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cap_valid,
  input  logic [ADDR_W-1:0]      pc_addr,
  input  logic [CMD_W-1:0]       cmd,
  input  logic                   arm,
  input  logic [ADDR_W-1:0]      trig_addr,
  input  logic [7:0]             post_cnt,
  output logic                   trc_valid,
  input  logic                   trc_ready,
  output logic [ADDR_W-1:0]      trc_addr,
  output logic [CMD_W-1:0]       trc_cmd,
  output logic                   trc_trig,
  output logic [15:0]            trc_ts,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   done,
  output logic [DROP_W-1:0]      drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  trace_state_e        r_state;
  trace_state_e        w_state_nxt;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [LVL_W-1:0]    r_level;
  logic [DROP_W-1:0]   r_drop;
  logic [ADDR_W-1:0]   r_trig_addr;
  logic [POST_W-1:0]   r_post;
  logic [POST_W-1:0]   r_remain;
  logic                w_cap;
  logic                w_hit;
  logic                w_full;
  logic                w_pop;
  trace_entry_t        w_wr_data;
  trace_entry_t        w_rd_data;

  // arm wins over any capture or pop in the same cycle
  assign w_cap  = cap_valid && !arm
               && is_capturing(r_state);
  assign w_hit  = (r_state == ARMED)
               && (pc_addr == r_trig_addr);
  assign w_full = (r_level == LVL_W'(DEPTH));
  assign w_pop  = trc_valid && trc_ready && !arm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (arm) begin
      w_state_nxt = ARMED;
    end else begin
      unique case (r_state)
        ARMED: begin
          if (w_cap && w_hit) begin
            w_state_nxt = (r_post == '0)
                        ? DONE : TRIGGERED;
          end
        end
        TRIGGERED: begin
          if (w_cap && r_remain == POST_W'(1)) begin
            w_state_nxt = DONE;
          end
        end
        DONE: begin
          if (w_pop && r_level == LVL_W'(1)) begin
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    trc_valid = 1'b0;
    unique case (r_state)
      ARMED, TRIGGERED: begin
        busy = 1'b1;
      end
      DONE: begin
        done      = 1'b1;
        trc_valid = (r_level != '0);
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // a write into a full buffer evicts the oldest entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_drop      <= '0;
      r_trig_addr <= '0;
      r_post      <= '0;
      r_remain    <= '0;
    end else if (arm) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_drop      <= '0;
      r_trig_addr <= trig_addr;
      r_post      <= post_cnt;
      r_remain    <= '0;
    end else if (w_cap) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_full) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        if (r_drop != '1) begin
          r_drop <= r_drop + 1'b1;
        end
      end else begin
        r_level <= r_level + 1'b1;
      end
      if (w_hit) begin
        r_remain <= r_post;
      end else if (r_state == TRIGGERED) begin
        r_remain <= r_remain - 1'b1;
      end
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level  <= r_level - 1'b1;
    end
  end

`ifdef PC_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ts <= '0;
    end else if (arm) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
    end
  end
`endif

  always_comb begin
    w_wr_data      = '0;
    w_wr_data.addr = pc_addr;
    w_wr_data.cmd  = cmd;
    w_wr_data.trig = w_hit;
`ifdef PC_TRACE_TIMESTAMP_EN
    w_wr_data.ts   = r_ts;
`endif
  end

  pc_trace_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_cap),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_wr_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  assign trc_addr = w_rd_data.addr;
  assign trc_cmd  = w_rd_data.cmd;
  assign trc_trig = w_rd_data.trig;
`ifdef PC_TRACE_TIMESTAMP_EN
  assign trc_ts   = w_rd_data.ts;
`else
  assign trc_ts   = '0;
`endif

  assign level    = r_level;
  assign drop_cnt = r_drop;

endmodule
